// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (I) and data access (D).
// D has priority, I is forced through after DSTREAK_MAX back-to-back D grants.
module mem_arbiter #(
  parameter int unsigned DSTREAK_MAX = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, next_state;
  logic [3:0] dstreak, dstreak_next;
  logic [7:0] timer, timer_next;
  logic       err_next;
  logic       d_req;
  logic       access;

  always_comb begin
    d_req  = dREN | dWEN;
    access = (ramstate == RAM_ACCESS);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      dstreak <= '0;
      timer   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= next_state;
      dstreak <= dstreak_next;
      timer   <= timer_next;
      err     <= err_next;
    end
  end

  always_comb begin
    next_state   = state;
    dstreak_next = dstreak;
    timer_next   = timer;
    err_next     = 1'b0;
    iwait        = 1'b1;
    iload        = '0;
    dwait        = 1'b1;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (d_req && iREN && dstreak == STREAK_MAX) begin
          next_state   = GNT_I;
          dstreak_next = '0;
        end else if (d_req) begin
          next_state   = GNT_D;
          dstreak_next = !iREN ? '0 :
                         (dstreak == STREAK_MAX) ? dstreak : dstreak + 4'd1;
        end else if (iREN) begin
          next_state   = GNT_I;
          dstreak_next = '0;
        end
      end

      GNT_I: begin
        // A dropped request aborts silently: no strobes, no response, no err.
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (access) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end else if (timer == TIMER_LAST) begin
            next_state = IDLE;
            err_next   = 1'b1;
          end else begin
            timer_next = timer + 8'd1;
          end
        end
      end

      GNT_D: begin
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (access) begin
            dwait      = 1'b0;
            dload      = dWEN ? '0 : ramload;
            next_state = IDLE;
          end else if (timer == TIMER_LAST) begin
            next_state = IDLE;
            err_next   = 1'b1;
          end else begin
            timer_next = timer + 8'd1;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand-written
// starvation, timeout and reset sequences.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef logic [132:0] out_t;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  rs;
    logic [31:0] rload;
    out_t        exp;
  } vec_t;

  function automatic out_t pack(input logic iw, input logic [31:0] il,
                                input logic dw, input logic [31:0] dl,
                                input logic rr, input logic rw,
                                input logic [31:0] ra, input logic [31:0] rst,
                                input logic e);
    return {iw, il, dw, dl, rr, rw, ra, rst, e};
  endfunction

  function automatic vec_t mk(input logic ir, input logic [31:0] ia,
                              input logic dr, input logic dwr,
                              input logic [31:0] da, input logic [31:0] ds,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input out_t ex);
    vec_t v;
    v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dwr;
    v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl; v.exp = ex;
    return v;
  endfunction

  function automatic out_t actual();
    return pack(iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwr, input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] rs, input logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dwr;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
  endtask

  vec_t vecs[25];
  out_t IDLEO;

  initial begin
    IDLEO = pack(1, 0, 1, 0, 0, 0, 0, 0, 0);

    // single I read, zero-wait RAM, then earliest re-grant
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, FREE, 0, IDLEO);
    vecs[1]  = mk(1, 32'h40, 0, 0, 0, 0, FREE, 0, IDLEO);
    vecs[2]  = mk(1, 32'h40, 0, 0, 0, 0, ACC, 32'h8C010004, pack(0, 32'h8C010004, 1, 0, 1, 0, 32'h40, 0, 0));
    vecs[3]  = mk(1, 32'h40, 0, 0, 0, 0, ACC, 32'h8C010004, IDLEO);
    vecs[4]  = mk(1, 32'h40, 0, 0, 0, 0, ACC, 32'h11111111, pack(0, 32'h11111111, 1, 0, 1, 0, 32'h40, 0, 0));
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, ACC, 0, IDLEO);
    // contention: D first, I after D is done
    vecs[6]  = mk(1, 32'h44, 1, 0, 32'h100, 32'h55, BUSY, 0, IDLEO);
    vecs[7]  = mk(1, 32'h44, 1, 0, 32'h100, 32'h55, BUSY, 0, pack(1, 0, 1, 0, 1, 0, 32'h100, 32'h55, 0));
    vecs[8]  = mk(1, 32'h44, 1, 0, 32'h100, 32'h55, ACC, 32'hAAAA5555, pack(1, 0, 0, 32'hAAAA5555, 1, 0, 32'h100, 32'h55, 0));
    vecs[9]  = mk(1, 32'h44, 0, 0, 32'h100, 32'h55, BUSY, 0, IDLEO);
    vecs[10] = mk(1, 32'h44, 0, 0, 0, 0, ACC, 32'h22, pack(0, 32'h22, 1, 0, 1, 0, 32'h44, 0, 0));
    vecs[11] = mk(0, 0, 0, 0, 0, 0, FREE, 0, IDLEO);
    // write priority with ERROR/BUSY retries
    vecs[12] = mk(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, FREE, 0, IDLEO);
    vecs[13] = mk(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, ERR, 0, pack(1, 0, 1, 0, 0, 1, 32'h200, 32'hDEADBEEF, 0));
    vecs[14] = mk(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, BUSY, 0, pack(1, 0, 1, 0, 0, 1, 32'h200, 32'hDEADBEEF, 0));
    vecs[15] = mk(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, ACC, 32'h12345678, pack(1, 0, 0, 0, 0, 1, 32'h200, 32'hDEADBEEF, 0));
    vecs[16] = mk(0, 0, 0, 0, 0, 0, FREE, 0, IDLEO);
    // I abort on dropped request; FREE in grant is not-done
    vecs[17] = mk(1, 32'h80, 0, 0, 0, 0, FREE, 0, IDLEO);
    vecs[18] = mk(1, 32'h80, 0, 0, 0, 0, FREE, 0, pack(1, 0, 1, 0, 1, 0, 32'h80, 0, 0));
    vecs[19] = mk(0, 32'h80, 0, 0, 0, 0, BUSY, 0, IDLEO);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, FREE, 0, IDLEO);
    // D abort on dropped request
    vecs[21] = mk(0, 0, 1, 0, 32'h300, 0, BUSY, 0, IDLEO);
    vecs[22] = mk(0, 0, 1, 0, 32'h300, 0, BUSY, 0, pack(1, 0, 1, 0, 1, 0, 32'h300, 0, 0));
    vecs[23] = mk(0, 0, 0, 0, 32'h300, 0, BUSY, 0, IDLEO);
    vecs[24] = mk(0, 0, 0, 0, 0, 0, FREE, 0, IDLEO);

    // reset with requests asserted
    nRST = 1'b0;
    drive(1, 32'h40, 1, 1, 32'h100, 32'h1, ACC, 32'h9);
    #3;
    check("reset_outputs", actual(), IDLEO);
    @(negedge CLK);
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, FREE, 0);

    for (int unsigned k = 0; k < 25; k++) begin
      @(negedge CLK);
      drive(vecs[k].iren, vecs[k].iaddr, vecs[k].dren, vecs[k].dwen,
            vecs[k].daddr, vecs[k].dstore, vecs[k].rs, vecs[k].rload);
      #2;
      check($sformatf("vec%0d", k), actual(), vecs[k].exp);
    end

    // starvation: I and D held, RAM always ready -> D x4, I, D x4, I
    begin
      int unsigned grants = 0;
      int unsigned cyc = 0;
      @(negedge CLK);
      drive(1, 32'h1000, 1, 0, 32'h2000, 0, ACC, 32'h5);
      while (grants < 10 && cyc < 40) begin
        #2;
        if (ramREN || ramWEN) begin
          logic [31:0] exp_addr;
          exp_addr = (grants == 4 || grants == 9) ? 32'h1000 : 32'h2000;
          check($sformatf("starve_grant%0d", grants), out_t'(ramaddr), out_t'(exp_addr));
          grants++;
        end
        cyc++;
        @(negedge CLK);
      end
      if (grants < 10) check("starve_budget", out_t'(grants), out_t'(10));
      drive(0, 0, 0, 0, 0, 0, FREE, 0);
      @(negedge CLK);
    end

    // timeout under I grant, one-cycle err, re-grant with timer restarted
    @(negedge CLK);
    drive(1, 32'h300, 0, 0, 0, 0, BUSY, 0);
    #2;
    check("to_decide", out_t'({ramREN, iwait, err}), out_t'(3'b010));
    for (int unsigned g = 1; g <= 8; g++) begin
      @(negedge CLK); #2;
      check($sformatf("to_grant%0d", g), out_t'({ramREN, iwait, err}), out_t'(3'b110));
    end
    @(negedge CLK); #2;
    check("to_err_idle", out_t'({ramREN, iwait, err}), out_t'(3'b011));
    for (int unsigned g = 1; g <= 7; g++) begin
      @(negedge CLK); #2;
      check($sformatf("regrant%0d", g), out_t'({ramREN, iwait, err}), out_t'(3'b110));
    end
    @(negedge CLK);
    ramstate = ACC; ramload = 32'h77;
    #2;
    check("access_at_limit", actual(), pack(0, 32'h77, 1, 0, 1, 0, 32'h300, 0, 0));
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, FREE, 0);
    #2;
    check("no_err_after_access", actual(), IDLEO);

    // reset in the middle of a D write
    @(negedge CLK);
    drive(0, 0, 1, 1, 32'h400, 32'hCAFEF00D, BUSY, 0);
    @(negedge CLK); #2;
    check("pre_reset_write", actual(), pack(1, 0, 1, 0, 0, 1, 32'h400, 32'hCAFEF00D, 0));
    #1 nRST = 1'b0;
    #1;
    check("reset_drops_strobes", out_t'({ramREN, ramWEN, iwait, dwait, ramaddr}), out_t'({4'b0011, 32'h0}));
    @(negedge CLK);
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, FREE, 0);
    #2;
    check("post_reset_idle", actual(), IDLEO);
    @(negedge CLK);
    drive(0, 0, 1, 1, 32'h400, 32'hCAFEF00D, BUSY, 0);
    #2;
    check("post_reset_decide", actual(), IDLEO);
    @(negedge CLK); #2;
    check("post_reset_grant", actual(), pack(1, 0, 1, 0, 0, 1, 32'h400, 32'hCAFEF00D, 0));
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0, FREE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
